// File: rtl/dcache_memory_responder.sv
// Memory-side responder arbitrating dcache/icache word requests onto one variable-latency RAM port.
// Optional DCACHE_MEM_STATS_EN: count completed dcache accesses on dstat_count.
module dcache_memory_responder #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dmem_ready,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        imem_ready,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic        ram_ready,
  input  logic [31:0] ramload,
  output logic [31:0] dstat_count
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {IDLE, D_ACCESS, I_ACCESS, D_DONE, I_DONE} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic [31:2]   addr_reg, addr_next;
  logic [31:0]   store_reg, store_next;
  logic [31:0]   data_reg, data_next;
  logic          wr_reg, wr_next;

  logic d_req;
  logic d_grant_ok;
  logic unused_addr_lsb;

  // Byte offset is never used: the RAM is word addressed.
  assign unused_addr_lsb = ^{daddr[1:0], iaddr[1:0]};

  assign d_req      = dREN | dWEN;
  assign d_grant_ok = d_req && !(iREN && (starve_reg == STARVE_MAX));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg  <= IDLE;
      starve_reg <= '0;
      addr_reg   <= '0;
      store_reg  <= '0;
      data_reg   <= '0;
      wr_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      starve_reg <= starve_next;
      addr_reg   <= addr_next;
      store_reg  <= store_next;
      data_reg   <= data_next;
      wr_reg     <= wr_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    starve_next = starve_reg;
    addr_next   = addr_reg;
    store_next  = store_reg;
    data_next   = data_reg;
    wr_next     = wr_reg;
    dmem_ready  = 1'b0;
    imem_ready  = 1'b0;
    dload       = 32'h0;
    iload       = 32'h0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = 32'h0;
    ramstore    = 32'h0;

    unique case (state_reg)
      IDLE: begin
        if (d_grant_ok) begin
          state_next = D_ACCESS;
          addr_next  = daddr[31:2];
          store_next = dstore;
          wr_next    = dWEN;
          if (iREN)
            starve_next = (starve_reg == STARVE_MAX) ? STARVE_MAX : starve_reg + 1'b1;
          else
            starve_next = '0;
        end else if (iREN) begin
          state_next  = I_ACCESS;
          addr_next   = iaddr[31:2];
          wr_next     = 1'b0;
          starve_next = '0;
        end
      end

      D_ACCESS: begin
        // A withdrawn request aborts even if the RAM finishes in the same cycle.
        if (!d_req) begin
          state_next = IDLE;
        end else begin
          ramREN   = !wr_reg;
          ramWEN   = wr_reg;
          ramaddr  = {addr_reg, 2'b00};
          ramstore = wr_reg ? store_reg : 32'h0;
          if (ram_ready) begin
            data_next  = wr_reg ? 32'h0 : ramload;
            state_next = D_DONE;
          end
        end
      end

      I_ACCESS: begin
        if (!iREN) begin
          state_next = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = {addr_reg, 2'b00};
          if (ram_ready) begin
            data_next  = ramload;
            state_next = I_DONE;
          end
        end
      end

      D_DONE: begin
        dmem_ready = 1'b1;
        dload      = data_reg;
        state_next = IDLE;
      end

      I_DONE: begin
        imem_ready = 1'b1;
        iload      = data_reg;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

`ifdef DCACHE_MEM_STATS_EN
  logic [31:0] stat_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)
      stat_reg <= 32'h0;
    else if (state_reg == D_DONE)
      stat_reg <= stat_reg + 32'h1;
  end

  assign dstat_count = stat_reg;
`else
  assign dstat_count = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_memory_responder.sv
// Scoreboard bench for dcache_memory_responder: stimulus pushes expected loads, a monitor pops on ready pulses.
module tb_dcache_memory_responder;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dREN = 1'b0, dWEN = 1'b0, iREN = 1'b0;
  logic [31:0] daddr = 32'h0, dstore = 32'h0, iaddr = 32'h0;
  logic        dmem_ready, imem_ready, ramREN, ramWEN, ram_ready;
  logic [31:0] dload, iload, ramaddr, ramstore, ramload, dstat_count;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_rr = -10;
  int          ram_lat = 0;
  int          wait_cnt = 0;
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_val = 32'h0;
  logic [31:0] dq[$];
  logic [31:0] iq[$];

  dcache_memory_responder #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dmem_ready(dmem_ready), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .imem_ready(imem_ready), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ram_ready(ram_ready), .ramload(ramload), .dstat_count(dstat_count)
  );

  always #5 CLK = ~CLK;

  // RAM stand-in: completes ram_lat cycles after the strobe rises; read data is ~address unless pinned.
  assign ram_ready = (ramREN | ramWEN) && (wait_cnt >= ram_lat);
  assign ramload   = fixed_en ? fixed_val : ~ramaddr;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!(ramREN | ramWEN) || ram_ready) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      #1;
      if (ram_ready) last_rr = cyc;
      chk("ready_overlap", 32'(dmem_ready & imem_ready), 32'h0);
      if (dmem_ready) begin
        chk("d_latency", 32'(cyc), 32'(last_rr + 1));
        chk("d_pending", 32'(dq.size() != 0), 32'h1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          chk("dload", dload, e);
        end
        $display("txn dcache done dload=0x%08h cycle=%0d", dload, cyc);
      end else begin
        chk("dload_idle", dload, 32'h0);
      end
      if (imem_ready) begin
        chk("i_latency", 32'(cyc), 32'(last_rr + 1));
        chk("i_pending", 32'(iq.size() != 0), 32'h1);
        if (iq.size() != 0) begin
          e = iq.pop_front();
          chk("iload", iload, e);
        end
        $display("txn icache done iload=0x%08h cycle=%0d", iload, cyc);
      end else begin
        chk("iload_idle", iload, 32'h0);
      end
    end
  end

  // Called at a negedge; returns what the RAM saw on the first strobed cycle.
  task automatic d_access(input logic we, input logic [31:0] a, input logic [31:0] st,
                          input int lat, input logic [31:0] exp,
                          output logic [31:0] s_addr, output logic [31:0] s_store,
                          output logic s_wen);
    bit seen = 0;
    bit done = 0;
    s_addr = 32'h0; s_store = 32'h0; s_wen = 1'b0;
    ram_lat = lat;
    dq.push_back(exp);
    dREN = !we; dWEN = we; daddr = a; dstore = st;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge CLK);
      if (!seen && (ramREN | ramWEN)) begin
        seen = 1; s_addr = ramaddr; s_store = ramstore; s_wen = ramWEN;
      end
      if (dmem_ready) done = 1;
    end
    dREN = 1'b0; dWEN = 1'b0;
    chk("d_handshake_done", 32'(done), 32'h1);
  endtask

  task automatic i_access(input logic [31:0] a, input int lat, input logic [31:0] exp);
    bit done = 0;
    ram_lat = lat;
    iq.push_back(exp);
    iREN = 1'b1; iaddr = a;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge CLK);
      if (imem_ready) done = 1;
    end
    iREN = 1'b0;
    chk("i_handshake_done", 32'(done), 32'h1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] sa, ss, exp_stat;
    logic        sw;
    logic [9:0]  order;
    int          n;

    #2;
    chk("rst_dmem_ready", 32'(dmem_ready), 32'h0);
    chk("rst_imem_ready", 32'(imem_ready), 32'h0);
    chk("rst_strobes", 32'({ramREN, ramWEN}), 32'h0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    chk("rst_ramstore", ramstore, 32'h0);
    chk("rst_dstat", dstat_count, 32'h0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    // Read with two-cycle RAM latency and pinned load data.
    fixed_en = 1'b1; fixed_val = 32'hDEAD_BEEF;
    d_access(1'b0, 32'h0000_0104, 32'h0, 2, 32'hDEAD_BEEF, sa, ss, sw);
    chk("rd_ramaddr", sa, 32'h0000_0104);
    chk("rd_is_read", 32'(sw), 32'h0);
    fixed_en = 1'b0;
    repeat (4) @(negedge CLK);

    // Unaligned address is word-aligned on the RAM side.
    d_access(1'b0, 32'h0000_010B, 32'h0, 0, 32'hFFFF_FEF7, sa, ss, sw);
    chk("unaligned_ramaddr", sa, 32'h0000_0108);

    // Write completing in the first access cycle returns zero data.
    d_access(1'b1, 32'h0000_3100, 32'h0000_0017, 0, 32'h0, sa, ss, sw);
    chk("wr_ramwen", 32'(sw), 32'h1);
    chk("wr_ramstore", ss, 32'h0000_0017);
    chk("wr_ramaddr", sa, 32'h0000_3100);
    repeat (2) @(negedge CLK);

    // Both caches hold requests: four dcache completions, then one icache.
    ram_lat = 0; daddr = 32'h200; iaddr = 32'h400;
    for (int k = 0; k < 8; k++) dq.push_back(32'hFFFF_FDFF);
    for (int k = 0; k < 2; k++) iq.push_back(32'hFFFF_FBFF);
    dREN = 1'b1; iREN = 1'b1;
    n = 0; order = '0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      @(negedge CLK);
      if (dmem_ready | imem_ready) begin
        order[n] = imem_ready;
        n++;
      end
    end
    dREN = 1'b0; iREN = 1'b0;
    chk("arb_count", 32'(n), 32'd10);
    chk("arb_order", 32'(order), 32'h0000_0210);
    repeat (3) @(negedge CLK);

    // Withdrawn dcache read while RAM is stalled.
    ram_lat = 1000; daddr = 32'h500; dREN = 1'b1;
    @(negedge CLK);
    chk("abort_ren_active", 32'(ramREN), 32'h1);
    dREN = 1'b0;
    @(negedge CLK);
    chk("abort_strobes_idle", 32'({ramREN, ramWEN}), 32'h0);
    repeat (4) @(negedge CLK);

    // Reset in the middle of a write.
    daddr = 32'h600; dstore = 32'h55; dWEN = 1'b1;
    @(negedge CLK);
    chk("rstmid_wen_active", 32'(ramWEN), 32'h1);
    nRST = 1'b0;
    #1;
    chk("rstmid_wen_dropped", 32'(ramWEN), 32'h0);
    chk("rstmid_dstat", dstat_count, 32'h0);
    chk("rstmid_no_ready", 32'(dmem_ready), 32'h0);
    dWEN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    chk("rstmid_idle", 32'({ramREN, ramWEN}), 32'h0);

    // Three dcache and two icache accesses for the statistics counter.
    d_access(1'b1, 32'h10, 32'h99, 1, 32'h0, sa, ss, sw);
    d_access(1'b0, 32'h10, 32'h0, 0, 32'hFFFF_FFEF, sa, ss, sw);
    i_access(32'h800, 2, 32'hFFFF_F7FF);
    d_access(1'b0, 32'h14, 32'h0, 1, 32'hFFFF_FFEB, sa, ss, sw);
    i_access(32'h804, 0, 32'hFFFF_F7FB);
    @(negedge CLK);
`ifdef DCACHE_MEM_STATS_EN
    exp_stat = 32'd3;
`else
    exp_stat = 32'd0;
`endif
    chk("dstat_count", dstat_count, exp_stat);

    repeat (3) @(negedge CLK);
    chk("dq_drained", 32'(dq.size()), 32'h0);
    chk("iq_drained", 32'(iq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
